pll_reset_seq: RTL and testbench

Reset and lock sequencer for the Gowin PLL wrapper. It runs on the always-on board input clock. It pulses the PLL `reset` pin at power-up and again after lock loss. It then qualifies `lock` (synchronize, debounce, timeout with bounded retries) and only then releases the active-low system reset for logic clocked by `clkout0`/`clkout1`.

---
 rtl/pll_reset_seq.sv | 144 ++++++++++++++
 tb/tb_pll_reset_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset pulse, lock qualification and system reset release sequencer
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_STABLE    = 1024,
    parameter int MAX_RETRY      = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                 clkin,
    input  logic                                 reset_n,
    input  logic                                 pll_lock,
    input  logic                                 soft_rst,
    output logic                                 pll_reset,
    output logic                                 sys_rst_n,
    output logic                                 ready,
    output logic                                 fail,
    output logic                                 lock_lost,
    output logic [$clog2(MAX_RETRY+1)-1:0]       retry_cnt,
    output logic [2:0]                           state
);

    // The single shared counter must reach the largest terminal count minus one.
    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RW        = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RW-1:0]    RETRY_LAST  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t                   cur;
    state_t                   nxt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [RW-1:0]            retry_nxt;
    logic                     lost_nxt;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     lock_s;
    logic                     pll_reset_d;
    logic                     run_d;
    logic                     fail_d;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign state  = cur;

    // Bring the asynchronous PLL lock into the clkin domain.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    // State register plus counter, retry/lost bookkeeping and outputs decoded from the next state.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            cur       <= S_RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            lock_lost <= 1'b0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            lock_lost <= lost_nxt;
            pll_reset <= pll_reset_d;
            sys_rst_n <= run_d;
            ready     <= run_d;
            fail      <= fail_d;
        end
    end

    // Next-state logic; soft_rst overrides every other transition and lock beats a timeout.
    always_comb begin
        nxt       = cur;
        retry_nxt = retry_cnt;
        lost_nxt  = lock_lost;
        if (soft_rst) begin
            nxt       = S_RESET_PLL;
            retry_nxt = '0;
            lost_nxt  = 1'b0;
        end else begin
            case (cur)
                S_RESET_PLL: begin
                    if (cnt == RST_LAST) nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        nxt = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt == RETRY_LAST) begin
                            nxt = S_FAIL;
                        end else begin
                            nxt       = S_RESET_PLL;
                            retry_nxt = retry_cnt + RW'(1);
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) nxt = S_WAIT_LOCK;
                    else if (cnt == STABLE_LAST) nxt = S_RUN;
                end
                S_RUN: begin
                    if (!lock_s) begin
                        nxt       = S_RESET_PLL;
                        retry_nxt = '0;
                        lost_nxt  = 1'b1;
                    end
                end
                S_FAIL: nxt = S_FAIL;
                default: nxt = S_RESET_PLL;
            endcase
        end
        // The counter restarts on any state change or restart request and idles in RUN/FAIL.
        if (soft_rst || (nxt != cur) || (cur == S_RUN) || (cur == S_FAIL)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Output decode from the next state so outputs move on the same edge as state.
    always_comb begin
        pll_reset_d = (nxt == S_RESET_PLL) || (nxt == S_FAIL);
        run_d       = (nxt == S_RUN);
        fail_d      = (nxt == S_FAIL);
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - directed self-checking bench for pll_reset_seq
module tb_pll_reset_seq;

    logic       clkin;
    logic       reset_n;
    logic       pll_lock;
    logic       soft_rst;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_seq #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .LOCK_STABLE    (8),
        .MAX_RETRY      (2),
        .SYNC_STAGES    (2)
    ) dut (
        .clkin     (clkin),
        .reset_n   (reset_n),
        .pll_lock  (pll_lock),
        .soft_rst  (soft_rst),
        .pll_reset (pll_reset),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fail      (fail),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    initial clkin = 1'b0;
    always #10 clkin = ~clkin;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        soft_rst = 1'b0;
        repeat (3) @(negedge clkin);
        n_checks++;
        if (state !== 3'd0 || pll_reset !== 1'b1 || sys_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_main: state=%0d pll_reset=%b sys_rst_n=%b required 0/1/0", state, pll_reset, sys_rst_n);
        end
        n_checks++;
        if (ready !== 1'b0 || fail !== 1'b0 || lock_lost !== 1'b0 || retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b fail=%b lock_lost=%b retry=%0d required 0/0/0/0", ready, fail, lock_lost, retry_cnt);
        end
    endtask

    task automatic test_power_up();
        int n;
        int m;
        reset_n = 1'b1;
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin
            n++;
            @(negedge clkin);
        end
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL pwr_pll_reset_len: got %0d cycles required 4", n);
        end
        repeat (10) @(negedge clkin);
        n_checks++;
        if (state !== 3'd1 || sys_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL pwr_wait_lock: state=%0d sys_rst_n=%b required 1/0", state, sys_rst_n);
        end
        pll_lock = 1'b1;
        m = 0;
        while (ready !== 1'b1 && m < 50) begin
            @(negedge clkin);
            m++;
        end
        n_checks++;
        if (m !== 11) begin
            n_fail++;
            $display("FAIL pwr_ready_latency: got %0d cycles required 11", m);
        end
        n_checks++;
        if (sys_rst_n !== 1'b1 || state !== 3'd3 || retry_cnt !== 2'd0 || pll_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL pwr_run: sys_rst_n=%b state=%0d retry=%0d pll_reset=%b required 1/3/0/0", sys_rst_n, state, retry_cnt, pll_reset);
        end
    endtask

    task automatic test_lock_loss();
        int j;
        int n;
        int m;
        pll_lock = 1'b0;
        j = 0;
        while (sys_rst_n === 1'b1 && j < 10) begin
            @(negedge clkin);
            j++;
        end
        n_checks++;
        if (j !== 3) begin
            n_fail++;
            $display("FAIL loss_sys_rst_latency: got %0d cycles required 3", j);
        end
        n_checks++;
        if (lock_lost !== 1'b1 || state !== 3'd0 || ready !== 1'b0 || pll_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_flags: lock_lost=%b state=%0d ready=%b pll_reset=%b required 1/0/0/1", lock_lost, state, ready, pll_reset);
        end
        n = 0;
        while (pll_reset === 1'b1 && n < 20) begin
            n++;
            @(negedge clkin);
        end
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL loss_pll_reset_len: got %0d cycles required 4", n);
        end
        pll_lock = 1'b1;
        m = 0;
        while (ready !== 1'b1 && m < 50) begin
            @(negedge clkin);
            m++;
        end
        n_checks++;
        if (m !== 11 || lock_lost !== 1'b1 || retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL loss_requalify: cycles=%0d lock_lost=%b retry=%0d required 11/1/0", m, lock_lost, retry_cnt);
        end
    endtask

    task automatic test_recovery();
        int j;
        pll_lock = 1'b0;
        j = 0;
        while (fail !== 1'b1 && j < 120) begin
            @(negedge clkin);
            j++;
        end
        n_checks++;
        if (j !== 75) begin
            n_fail++;
            $display("FAIL rec_fail_latency: got %0d cycles required 75", j);
        end
        n_checks++;
        if (lock_lost !== 1'b1 || retry_cnt !== 2'd2 || pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL rec_in_fail: lock_lost=%b retry=%0d pll_reset=%b sys_rst_n=%b state=%0d required 1/2/1/0/4",
                     lock_lost, retry_cnt, pll_reset, sys_rst_n, state);
        end
        repeat (5) @(negedge clkin);
        n_checks++;
        if (state !== 3'd4 || fail !== 1'b1) begin
            n_fail++;
            $display("FAIL rec_fail_terminal: state=%0d fail=%b required 4/1", state, fail);
        end
        soft_rst = 1'b1;
        @(negedge clkin);
        soft_rst = 1'b0;
        n_checks++;
        if (state !== 3'd0 || fail !== 1'b0 || retry_cnt !== 2'd0 || lock_lost !== 1'b0 || pll_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL rec_soft_rst: state=%0d fail=%b retry=%0d lock_lost=%b pll_reset=%b required 0/0/0/0/1",
                     state, fail, retry_cnt, lock_lost, pll_reset);
        end
        repeat (23) @(negedge clkin);
        n_checks++;
        if (state !== 3'd1 || retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL rec_pre_timeout: state=%0d retry=%0d required 1/0", state, retry_cnt);
        end
        soft_rst = 1'b1;
        @(negedge clkin);
        soft_rst = 1'b0;
        n_checks++;
        if (state !== 3'd0 || retry_cnt !== 2'd0 || pll_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL rec_soft_vs_timeout: state=%0d retry=%0d pll_reset=%b required 0/0/1", state, retry_cnt, pll_reset);
        end
        repeat (3) @(negedge clkin);
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL rec_cnt_restart_hold: state=%0d required 0", state);
        end
        @(negedge clkin);
        n_checks++;
        if (state !== 3'd1 || pll_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL rec_cnt_restart_exit: state=%0d pll_reset=%b required 1/0", state, pll_reset);
        end
    endtask

    task automatic test_glitch();
        logic [2:0] exp_state [19];
        int n;
        exp_state = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1,
                      3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
        pll_lock = 1'b0;
        reset_n  = 1'b0;
        @(negedge clkin);
        reset_n = 1'b1;
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin
            n++;
            @(negedge clkin);
        end
        pll_lock = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clkin);
            n_checks++;
            if (state !== exp_state[k-1]) begin
                n_fail++;
                $display("FAIL glitch_state[%0d]: got %0d required %0d", k, state, exp_state[k-1]);
            end
            n_checks++;
            if (ready !== (k == 19)) begin
                n_fail++;
                $display("FAIL glitch_ready[%0d]: got %b required %b", k, ready, (k == 19));
            end
            if (k == 5) pll_lock = 1'b0;
            if (k == 8) pll_lock = 1'b1;
        end
        n_checks++;
        if (retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL glitch_retry: got %0d required 0", retry_cnt);
        end
    endtask

    task automatic test_no_lock();
        int run_len;
        int npulse;
        int fail_k;
        int lens [8];
        run_len = 0;
        npulse  = 0;
        fail_k  = -1;
        for (int i = 0; i < 8; i++) lens[i] = 0;
        pll_lock = 1'b0;
        reset_n  = 1'b0;
        @(negedge clkin);
        reset_n = 1'b1;
        for (int k = 0; k <= 80; k++) begin
            if (k > 0) @(negedge clkin);
            if (pll_reset === 1'b1 && fail !== 1'b1) begin
                run_len++;
            end else if (run_len > 0) begin
                if (npulse < 8) lens[npulse] = run_len;
                npulse++;
                run_len = 0;
            end
            if (fail === 1'b1 && fail_k < 0) fail_k = k;
            if (k == 23 || k == 24 || k == 48) begin
                n_checks++;
                if (retry_cnt !== ((k == 23) ? 2'd0 : (k == 24) ? 2'd1 : 2'd2)) begin
                    n_fail++;
                    $display("FAIL nolock_retry[%0d]: got %0d", k, retry_cnt);
                end
            end
        end
        n_checks++;
        if (npulse !== 3) begin
            n_fail++;
            $display("FAIL nolock_pulse_count: got %0d required 3", npulse);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lens[i] !== 4) begin
                n_fail++;
                $display("FAIL nolock_pulse_len[%0d]: got %0d required 4", i, lens[i]);
            end
        end
        n_checks++;
        if (fail_k !== 72) begin
            n_fail++;
            $display("FAIL nolock_fail_time: got %0d required 72", fail_k);
        end
        n_checks++;
        if (fail !== 1'b1 || pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL nolock_fail_outputs: fail=%b pll_reset=%b sys_rst_n=%b state=%0d required 1/1/0/4",
                     fail, pll_reset, sys_rst_n, state);
        end
    endtask

    task automatic test_async_reset();
        int w;
        int m;
        pll_lock = 1'b1;
        reset_n  = 1'b0;
        @(negedge clkin);
        reset_n = 1'b1;
        w = 0;
        while (state !== 3'd2 && w < 20) begin
            @(negedge clkin);
            w++;
        end
        n_checks++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL arst_reach_stable: state=%0d required 2", state);
        end
        repeat (3) @(negedge clkin);
        @(posedge clkin);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0 || pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 ||
            fail !== 1'b0 || lock_lost !== 1'b0 || retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL arst_mid_stable: state=%0d pll_reset=%b sys_rst_n=%b ready=%b fail=%b lost=%b retry=%0d required 0/1/0/0/0/0/0",
                     state, pll_reset, sys_rst_n, ready, fail, lock_lost, retry_cnt);
        end
        @(negedge clkin);
        reset_n = 1'b1;
        m = 0;
        while (ready !== 1'b1 && m < 40) begin
            @(negedge clkin);
            m++;
        end
        n_checks++;
        if (m !== 13) begin
            n_fail++;
            $display("FAIL arst_restart1: got %0d cycles required 13", m);
        end
        repeat (2) @(negedge clkin);
        @(posedge clkin);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0 || pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_mid_run: state=%0d pll_reset=%b sys_rst_n=%b ready=%b required 0/1/0/0",
                     state, pll_reset, sys_rst_n, ready);
        end
        @(negedge clkin);
        reset_n = 1'b1;
        m = 0;
        while (ready !== 1'b1 && m < 40) begin
            @(negedge clkin);
            m++;
        end
        n_checks++;
        if (m !== 13 || sys_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_restart2: cycles=%0d sys_rst_n=%b required 13/1", m, sys_rst_n);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_recovery();
        test_glitch();
        test_no_lock();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
